// File: rtl/iob_split_reg_pkg.sv
// Shared definitions for the registered IOb bus splitter: FSM state encodings,
// error-response fill value and helpers that size the packed request/response buses.
// Build option: IOB_SPLIT_REG_TIMEOUT_EN enables the ACCESS-phase timeout.
package iob_split_reg_pkg;

  // FSM state encodings; IDLE must stay 0 so a cleared state register is idle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Every rdata bit is driven to this value on a decode error or timeout.
  localparam logic ERR_DATA_BIT = 1'b1;

  // Select field width; a single slave still uses one bit so that 1 decodes as an error.
  function automatic int sel_width(input int n_slaves);
    int w;
    w = $clog2(n_slaves);
    return (w < 1) ? 1 : w;
  endfunction

  // Request bus {valid, addr, wdata, wstrb}.
  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // Response bus {rdata, ready}.
  function automatic int resp_width(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/iob_split_reg_timer.sv
// ACCESS-phase watchdog: counts cycles spent waiting for a slave ready.
// Latency: tc is combinational from the count register and enable, no extra cycle.
// Backpressure: none; the FSM decides when to clear or advance the count.
module iob_split_reg_timer #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // tc fires in the waiting cycle whose increment brings the count to all-ones,
  // so a slave gets 2^W-1 ACCESS cycles to answer before the transfer is dropped.
  localparam logic [W-1:0] TC_VAL = ~W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = en && !clr && (cnt_q == TC_VAL);

endmodule

// File: rtl/iob_split_reg.sv
// Registered IOb splitter: decodes addr[P_SLAVES -: SEL_W] and forwards one transfer at a time.
// Latency: slave valid 1 cycle after the request, master ready 1 cycle after slave ready (min 3).
// Backpressure: master requests are not sampled while busy; optional timeout via IOB_SPLIT_REG_TIMEOUT_EN.
module iob_split_reg
  import iob_split_reg_pkg::*;
#(
  parameter  int N_SLAVES  = 3,
  parameter  int P_SLAVES  = 23,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int TIMEOUT_W = 8,
  localparam int SEL_W     = sel_width(N_SLAVES),
  localparam int STRB_W    = DATA_W / 8,
  localparam int REQ_W     = req_width(ADDR_W, DATA_W),
  localparam int RESP_W    = resp_width(DATA_W)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_W-1:0]             m_req,
  output logic [RESP_W-1:0]            m_resp,
  output logic [N_SLAVES*REQ_W-1:0]    s_req,
  input  logic [N_SLAVES*RESP_W-1:0]   s_resp,
  output logic                         busy,
  output logic                         err
);

  // Number of slaves at select width plus one, so the range compare never truncates.
  localparam logic [SEL_W:0] N_SEL = (SEL_W + 1)'(N_SLAVES);

  // Master request fields.
  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic [SEL_W-1:0]  m_sel;
  logic              dec_ok;

  assign m_valid = m_req[REQ_W-1];
  assign m_addr  = m_req[REQ_W-2 -: ADDR_W];
  assign m_wdata = m_req[STRB_W +: DATA_W];
  assign m_wstrb = m_req[STRB_W-1:0];
  assign m_sel   = m_addr[P_SLAVES -: SEL_W];
  assign dec_ok  = ({1'b0, m_sel} < N_SEL);

  // Transfer state.
  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Response of the currently selected slave; other slaves are never looked at.
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;

  // Timer handshake.
  logic tmr_clr;
  logic tmr_en;
  logic tmr_tc;

  // Error pulse before reset gating.
  logic err_raw;

  // Pick the selected slave's response out of the flat response bus.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ready = s_resp[i*RESP_W];
        sel_rdata = s_resp[i*RESP_W+1 +: DATA_W];
      end
    end
  end

  // FSM next state, request latching and response capture.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    err_raw = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m_valid) begin
          if (dec_ok) begin
            state_d = ST_ACCESS;
            sel_d   = m_sel;
            addr_d  = m_addr;
            wdata_d = m_wdata;
            wstrb_d = m_wstrb;
            tmr_clr = 1'b1;
          end else begin
            // Unmapped select: answer directly with the error pattern, no slave access.
            state_d = ST_RESP;
            rdata_d = {DATA_W{ERR_DATA_BIT}};
            err_raw = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          // A ready on the terminal-count cycle still completes normally.
          state_d = ST_RESP;
          rdata_d = sel_rdata;
        end else begin
          tmr_en = 1'b1;
          if (tmr_tc) begin
            state_d = ST_RESP;
            rdata_d = {DATA_W{ERR_DATA_BIT}};
            err_raw = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and transfer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef IOB_SPLIT_REG_TIMEOUT_EN
  iob_split_reg_timer #(
    .W(TIMEOUT_W)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );
`else
  // No watchdog: ACCESS waits for the slave indefinitely.
  logic unused_tmr;
  assign tmr_tc     = 1'b0;
  assign unused_tmr = tmr_clr ^ tmr_en ^ (TIMEOUT_W > 0);
`endif

  // Slave request demux: only the latched slave sees valid, and only while in ACCESS.
  always_comb begin
    s_req = '0;
    if (state_q == ST_ACCESS) begin
      for (int i = 0; i < N_SLAVES; i++) begin
        if (sel_q == SEL_W'(i)) begin
          s_req[i*REQ_W +: REQ_W] = {1'b1, addr_q, wdata_q, wstrb_q};
        end
      end
    end
  end

  // Master response is a one-cycle ready carrying the captured data.
  assign m_resp = (state_q == ST_RESP) ? {rdata_q, 1'b1} : '0;
  assign busy   = (state_q != ST_IDLE);
  // err marks the transition into RESP on a fault; held low while reset is asserted.
  assign err    = err_raw && !rst;

endmodule

// File: tb/tb_iob_split_reg.sv
// Directed bench for iob_split_reg (N_SLAVES=3, P_SLAVES=23, TIMEOUT_W=4).
// Slaves are zero-wait models with per-slave stall and stray-ready controls.
// Honours IOB_SPLIT_REG_TIMEOUT_EN for the timeout scenario.
module tb_iob_split_reg;

  localparam int NS   = 3;
  localparam int RQW  = 69;
  localparam int RSW  = 33;

  logic              clk = 1'b0;
  logic              rst;
  logic [RQW-1:0]    m_req;
  logic [RSW-1:0]    m_resp;
  logic [NS*RQW-1:0] s_req;
  logic [NS*RSW-1:0] s_resp;
  logic              busy;
  logic              err;

  logic [31:0]       slv_rdata [NS];
  logic [NS-1:0]     slv_stall;
  logic [NS-1:0]     slv_force;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iob_split_reg #(
    .N_SLAVES (3),
    .P_SLAVES (23),
    .ADDR_W   (32),
    .DATA_W   (32),
    .TIMEOUT_W(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .m_req  (m_req),
    .m_resp (m_resp),
    .s_req  (s_req),
    .s_resp (s_resp),
    .busy   (busy),
    .err    (err)
  );

  // Slave models: ready with data whenever their valid is high, unless stalled.
  always_comb begin
    s_resp = '0;
    for (int i = 0; i < NS; i++) begin
      s_resp[i*RSW +: RSW] = {slv_rdata[i],
                              (s_req[i*RQW + RQW - 1] & ~slv_stall[i]) | slv_force[i]};
    end
  end

  function automatic logic [RQW-1:0] mk_req(input logic v, input logic [31:0] a,
                                            input logic [31:0] d, input logic [3:0] s);
    return {v, a, d, s};
  endfunction

  function automatic logic [RSW-1:0] mk_resp(input logic [31:0] rd);
    return {rd, 1'b1};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every slave request must be zero except slave 'sel' which must equal 'exp'.
  task automatic chk_sreq(input string tag, input int sel, input logic [RQW-1:0] exp);
    for (int i = 0; i < NS; i++) begin
      check($sformatf("%s_s%0d", tag, i), s_req[i*RQW +: RQW], (i == sel) ? exp : '0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [RQW-1:0] r;
    rst       = 1'b1;
    m_req     = '0;
    slv_stall = '0;
    slv_force = '0;
    for (int i = 0; i < NS; i++) slv_rdata[i] = 32'h0;
    tick();
    tick();
    #1;
    // Reset state
    check("rst_mresp", m_resp, 0);
    chk_sreq("rst_sreq", -1, '0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick();

    // 1: read slave1, zero wait
    r = mk_req(1'b1, 32'h0040_0010, 32'h0, 4'h0);
    m_req = r;
    slv_rdata[1] = 32'h1234_5678;
    #1;
    check("t1_c0_busy", busy, 0);
    check("t1_c0_err", err, 0);
    chk_sreq("t1_c0", -1, '0);
    tick(); #1;
    chk_sreq("t1_c1", 1, r);
    check("t1_c1_mresp", m_resp, 0);
    check("t1_c1_busy", busy, 1);
    tick(); #1;
    check("t1_c2_mresp", m_resp, mk_resp(32'h1234_5678));
    chk_sreq("t1_c2", -1, '0);
    m_req = '0;
    tick(); #1;
    check("t1_c3_busy", busy, 0);
    check("t1_c3_mresp", m_resp, 0);

    // 2: write slave2, ready held low 5 cycles, stray ready from slave0 ignored
    r = mk_req(1'b1, 32'h0080_0004, 32'hA5A5_A5A5, 4'hF);
    m_req = r;
    slv_rdata[2] = 32'hDEAD_BEEF;
    slv_stall[2] = 1'b1;
    slv_force[0] = 1'b1;
    tick();
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk_sreq($sformatf("t2_c%0d", c), 2, r);
      check($sformatf("t2_c%0d_mresp", c), m_resp, 0);
      check($sformatf("t2_c%0d_busy", c), busy, 1);
      tick();
    end
    slv_stall[2] = 1'b0;
    slv_force[0] = 1'b0;
    #1;
    chk_sreq("t2_c6", 2, r);
    check("t2_c6_mresp", m_resp, 0);
    tick(); #1;
    check("t2_c7_mresp", m_resp, mk_resp(32'hDEAD_BEEF));
    check("t2_c7_busy", busy, 1);
    chk_sreq("t2_c7", -1, '0);
    m_req = '0;
    tick(); #1;
    check("t2_c8_busy", busy, 0);

    // 3: decode error, stray readies everywhere must not matter
    m_req = mk_req(1'b1, 32'h00C0_0000, 32'h0, 4'h0);
    slv_force = 3'b111;
    #1;
    check("t3_c0_err", err, 1);
    chk_sreq("t3_c0", -1, '0);
    tick(); #1;
    check("t3_c1_mresp", m_resp, mk_resp(32'hFFFF_FFFF));
    check("t3_c1_err", err, 0);
    chk_sreq("t3_c1", -1, '0);
    m_req = '0;
    slv_force = '0;
    tick(); #1;
    check("t3_c2_busy", busy, 0);
    check("t3_c2_mresp", m_resp, 0);

    // 4: back-to-back, valid stays high with a new address after ready
    r = mk_req(1'b1, 32'h0040_0020, 32'h0, 4'h0);
    m_req = r;
    slv_rdata[1] = 32'h1111_1111;
    slv_rdata[0] = 32'h2222_2222;
    tick(); #1;
    chk_sreq("t4_c1", 1, r);
    tick(); #1;
    check("t4_c2_mresp", m_resp, mk_resp(32'h1111_1111));
    r = mk_req(1'b1, 32'h0000_0008, 32'h0, 4'h0);
    m_req = r;
    tick(); #1;
    check("t4_c3_busy", busy, 0);
    chk_sreq("t4_c3", -1, '0);
    tick(); #1;
    chk_sreq("t4_c4", 0, r);
    tick(); #1;
    check("t4_c5_mresp", m_resp, mk_resp(32'h2222_2222));
    chk_sreq("t4_c5", -1, '0);
    m_req = '0;
    tick(); #1;
    check("t4_c6_busy", busy, 0);
    chk_sreq("t4_c6", -1, '0);

    // 5: slave1 never ready
    r = mk_req(1'b1, 32'h0040_0030, 32'h0, 4'h0);
    m_req = r;
    slv_stall[1] = 1'b1;
    slv_rdata[1] = 32'h3333_3333;
    tick();
`ifdef IOB_SPLIT_REG_TIMEOUT_EN
    for (int c = 1; c <= 15; c++) begin
      #1;
      chk_sreq($sformatf("t5_c%0d", c), 1, r);
      check($sformatf("t5_c%0d_err", c), err, (c == 15));
      tick();
    end
    #1;
    chk_sreq("t5_to", -1, '0);
    check("t5_to_mresp", m_resp, mk_resp(32'hFFFF_FFFF));
    check("t5_to_err", err, 0);
    m_req = '0;
    slv_stall[1] = 1'b0;
    tick(); #1;
    check("t5_end_busy", busy, 0);
`else
    for (int c = 1; c < 100; c++) tick();
    #1;
    check("t5_busy100", busy, 1);
    chk_sreq("t5_c100", 1, r);
    check("t5_c100_mresp", m_resp, 0);
    check("t5_c100_err", err, 0);
    slv_stall[1] = 1'b0;
    tick(); #1;
    check("t5_rel_mresp", m_resp, mk_resp(32'h3333_3333));
    m_req = '0;
    tick(); #1;
    check("t5_end_busy", busy, 0);
`endif

    // 6: reset during ACCESS aborts silently, next read completes
    r = mk_req(1'b1, 32'h0080_0040, 32'h0, 4'h0);
    m_req = r;
    slv_stall[2] = 1'b1;
    tick(); #1;
    chk_sreq("t6_c1", 2, r);
    rst = 1'b1;
    tick(); #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_mresp", m_resp, 0);
    check("t6_rst_err", err, 0);
    chk_sreq("t6_rst", -1, '0);
    rst = 1'b0;
    m_req = '0;
    slv_stall[2] = 1'b0;
    tick(); #1;
    check("t6_after_mresp", m_resp, 0);
    check("t6_after_busy", busy, 0);
    r = mk_req(1'b1, 32'h0000_0010, 32'h0, 4'h0);
    m_req = r;
    slv_rdata[0] = 32'h0BAD_F00D;
    tick(); #1;
    chk_sreq("t6_rd_c1", 0, r);
    tick(); #1;
    check("t6_rd_mresp", m_resp, mk_resp(32'h0BAD_F00D));
    m_req = '0;
    tick(); #1;
    check("t6_rd_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
